// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command-decoded byte RAM sitting behind an SPI slave (WR_ADDR/WR_DATA/RD_ADDR/RD_DATA).
// Optional macro SPI_RAM_AUTOINC_EN: post-increment write/read addresses for burst access.
module spi_ram_ctrl #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       seq_err
);

  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_TX   = 2'd2
  } state_e;

  state_e               state_q;
  logic [ADDR_SIZE-1:0] wr_addr_q;
  logic [ADDR_SIZE-1:0] rd_addr_q;
  logic                 wr_addr_vld_q;
  logic                 rd_addr_vld_q;
  logic [DATA_W-1:0]    mem [MEM_DEPTH];

  logic [1:0]        op;
  logic [DATA_W-1:0] payload;
  logic              wr_addr_cmd;
  logic              wr_data_cmd;
  logic              rd_addr_cmd;
  logic              rd_data_cmd;
  logic              wr_en;
  logic              rd_go;

  // Command decode; din is only meaningful while rx_valid is high.
  assign op          = din[9:8];
  assign payload     = din[7:0];
  assign wr_addr_cmd = rx_valid && (op == OP_WR_ADDR);
  assign wr_data_cmd = rx_valid && (op == OP_WR_DATA);
  assign rd_addr_cmd = rx_valid && (op == OP_RD_ADDR);
  assign rd_data_cmd = rx_valid && (op == OP_RD_DATA);
  assign wr_en       = wr_data_cmd && wr_addr_vld_q;
  assign rd_go       = rd_data_cmd && rd_addr_vld_q;

  // Storage is deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr_q] <= payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      dout          <= '0;
      tx_valid      <= 1'b0;
      seq_err       <= 1'b0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      wr_addr_vld_q <= 1'b0;
      rd_addr_vld_q <= 1'b0;
    end else begin
      seq_err <= (wr_data_cmd && !wr_addr_vld_q) || (rd_data_cmd && !rd_addr_vld_q);

      if (wr_addr_cmd) begin
        wr_addr_q     <= ADDR_SIZE'(payload);
        wr_addr_vld_q <= 1'b1;
      end
`ifdef SPI_RAM_AUTOINC_EN
      else if (wr_en) begin
        wr_addr_q <= wr_addr_q + ADDR_SIZE'(1);
      end
`endif

      // An explicit RD_ADDR landing in the S_READ cycle wins over the burst increment.
      if (rd_addr_cmd) begin
        rd_addr_q     <= ADDR_SIZE'(payload);
        rd_addr_vld_q <= 1'b1;
      end
`ifdef SPI_RAM_AUTOINC_EN
      else if (state_q == S_READ) begin
        rd_addr_q <= rd_addr_q + ADDR_SIZE'(1);
      end
`endif

      case (state_q)
        S_IDLE: begin
          if (rd_go) begin
            state_q  <= S_READ;
            tx_valid <= 1'b0;
          end else if (rd_addr_cmd) begin
            tx_valid <= 1'b0;
          end
        end
        S_READ: begin
          dout     <= mem[rd_addr_q];
          tx_valid <= 1'b1;
          state_q  <= S_TX;
        end
        S_TX: begin
          if (rx_valid) begin
            tx_valid <= 1'b0;
            state_q  <= rd_go ? S_READ : S_IDLE;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
